// File: rtl/mps_mc_seq_if.sv
// Contactor-sequencer signal bundle: requests, DC-link qualification and
// contactor feedback toward the sequencer; drive, status and fault code back out.
interface mps_mc_seq_if #(
  parameter int DC_V_W = 32
) ();
  logic              i_start;
  logic              i_stop;
  logic              i_intl;
  logic              i_fail_clr;
  logic [DC_V_W-1:0] i_dc_v;
  logic [DC_V_W-1:0] i_dc_v_th;
  logic [2:0]        i_mc_fb;
  logic [2:0]        o_mc;
  logic [3:0]        o_state;
  logic              o_done;
  logic              o_fail;
  logic [3:0]        o_fail_code;

  modport master (
    output i_start, i_stop, i_intl, i_fail_clr, i_dc_v, i_dc_v_th, i_mc_fb,
    input  o_mc, o_state, o_done, o_fail, o_fail_code
  );

  modport slave (
    input  i_start, i_stop, i_intl, i_fail_clr, i_dc_v, i_dc_v_th, i_mc_fb,
    output o_mc, o_state, o_done, o_fail, o_fail_code
  );
endinterface

// File: rtl/mps_mc_seq.sv
// Magnetic-contactor power-up/power-down sequencer (precharge, main, discharge).
// Optional contactor aux-feedback supervision is enabled by defining MC_FB_CHECK_EN.
module mps_mc_seq #(
  parameter int DC_V_W     = 32,
  parameter int MC_DLY     = 1000,
  parameter int V_DEB      = 16,
  parameter int PC_TIMEOUT = 200000,
  parameter int DIS_TIME   = 5000
) (
  input  logic         i_clk,
  input  logic         i_rst,
  mps_mc_seq_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    PC_CLOSE   = 4'd1,
    PC_WAIT_V  = 4'd2,
    MAIN_CLOSE = 4'd3,
    PC_OPEN    = 4'd4,
    ON         = 4'd5,
    MAIN_OPEN  = 4'd6,
    DISCHARGE  = 4'd7,
    FAULT      = 4'd8
  } state_t;

  localparam logic [31:0] MC_END  = 32'(MC_DLY - 1);
  localparam logic [31:0] PC_END  = 32'(PC_TIMEOUT - 1);
  localparam logic [31:0] DIS_END = 32'(DIS_TIME - 1);
  localparam logic [31:0] DEB_N   = 32'(V_DEB);

  localparam logic [3:0] CODE_NONE   = 4'd0;
  localparam logic [3:0] CODE_PC_FB  = 4'd1;
  localparam logic [3:0] CODE_PC_TMO = 4'd2;
  localparam logic [3:0] CODE_MC_FB  = 4'd3;
  localparam logic [3:0] CODE_PO_FB  = 4'd4;
  localparam logic [3:0] CODE_INTL   = 4'd5;
  localparam logic [3:0] CODE_ON_FB  = 4'd6;

  // Contactor drive pattern {dis, main, pc} for each state.
  function automatic logic [2:0] mc_decode(input state_t s);
    logic [2:0] mc;
    case (s)
      PC_CLOSE, PC_WAIT_V: mc = 3'b001;
      MAIN_CLOSE:          mc = 3'b011;
      PC_OPEN, ON:         mc = 3'b010;
      DISCHARGE, FAULT:    mc = 3'b100;
      default:             mc = 3'b000;
    endcase
    return mc;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] tmr_q, tmr_d;
  logic [31:0] deb_q, deb_d;
  logic [3:0]  code_q, code_d;
  logic [2:0]  mc_q, mc_d;
  logic        done_q, done_d;
  logic        fail_q, fail_d;

  logic [DC_V_W-1:0] dc_v;
  logic [DC_V_W-1:0] dc_th;
  logic              v_ok;
  logic              step_ok;
  logic              fb_tmo;
  logic              on_fb_flt;

  assign dc_v  = bus.i_dc_v;
  assign dc_th = bus.i_dc_v_th;
  assign v_ok  = (dc_v >= dc_th);

`ifdef MC_FB_CHECK_EN
  localparam logic [31:0] FB_END = 32'(4 * MC_DLY - 1);

  logic [31:0] fb_cnt_q, fb_cnt_d;
  logic        fb_match;
  logic        on_fb_bad;

  // Closing states advance only once the aux contacts agree with the drive.
  assign fb_match  = (bus.i_mc_fb == mc_decode(state_q));
  assign step_ok   = (tmr_q >= MC_END) && fb_match;
  assign fb_tmo    = (tmr_q == FB_END) && !fb_match;
  assign on_fb_bad = (state_q == ON) && (bus.i_mc_fb != 3'b010);
  assign on_fb_flt = on_fb_bad && (fb_cnt_q == MC_END);
  assign fb_cnt_d  = on_fb_bad ? sat_inc(fb_cnt_q) : '0;
`else
  logic unused_fb;

  assign unused_fb = ^bus.i_mc_fb;
  assign step_ok   = (tmr_q == MC_END);
  assign fb_tmo    = 1'b0;
  assign on_fb_flt = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    deb_d   = '0;

    case (state_q)
      IDLE: begin
        if (bus.i_start && !bus.i_intl) state_d = PC_CLOSE;
      end

      PC_CLOSE: begin
        if (bus.i_intl) begin
          state_d = FAULT;
          code_d  = CODE_INTL;
        end else if (fb_tmo) begin
          state_d = FAULT;
          code_d  = CODE_PC_FB;
        end else if (bus.i_stop) begin
          state_d = MAIN_OPEN;
        end else if (step_ok) begin
          state_d = PC_WAIT_V;
        end
      end

      PC_WAIT_V: begin
        // Debounce counts consecutive qualifying samples; any miss restarts it.
        deb_d = v_ok ? deb_q + 32'd1 : '0;
        if (bus.i_intl) begin
          state_d = FAULT;
          code_d  = CODE_INTL;
        end else if (tmr_q == PC_END) begin
          state_d = FAULT;
          code_d  = CODE_PC_TMO;
        end else if (bus.i_stop) begin
          state_d = MAIN_OPEN;
        end else if (v_ok && (deb_q + 32'd1 == DEB_N)) begin
          state_d = MAIN_CLOSE;
        end
      end

      MAIN_CLOSE: begin
        if (bus.i_intl) begin
          state_d = FAULT;
          code_d  = CODE_INTL;
        end else if (fb_tmo) begin
          state_d = FAULT;
          code_d  = CODE_MC_FB;
        end else if (bus.i_stop) begin
          state_d = MAIN_OPEN;
        end else if (step_ok) begin
          state_d = PC_OPEN;
        end
      end

      PC_OPEN: begin
        if (bus.i_intl) begin
          state_d = FAULT;
          code_d  = CODE_INTL;
        end else if (fb_tmo) begin
          state_d = FAULT;
          code_d  = CODE_PO_FB;
        end else if (bus.i_stop) begin
          state_d = MAIN_OPEN;
        end else if (step_ok) begin
          state_d = ON;
        end
      end

      ON: begin
        if (bus.i_intl) begin
          state_d = FAULT;
          code_d  = CODE_INTL;
        end else if (on_fb_flt) begin
          state_d = FAULT;
          code_d  = CODE_ON_FB;
        end else if (bus.i_stop) begin
          state_d = MAIN_OPEN;
        end
      end

      MAIN_OPEN: begin
        if (bus.i_intl) begin
          state_d = FAULT;
          code_d  = CODE_INTL;
        end else if (tmr_q == MC_END) begin
          state_d = DISCHARGE;
        end
      end

      DISCHARGE: begin
        if (bus.i_intl) begin
          state_d = FAULT;
          code_d  = CODE_INTL;
        end else if (tmr_q == DIS_END) begin
          state_d = IDLE;
        end
      end

      FAULT: begin
        if (bus.i_fail_clr && !bus.i_intl) begin
          state_d = IDLE;
          code_d  = CODE_NONE;
        end
      end

      default: begin
        state_d = IDLE;
        code_d  = CODE_NONE;
      end
    endcase

    tmr_d  = (state_d != state_q) ? '0 : sat_inc(tmr_q);
    mc_d   = mc_decode(state_d);
    done_d = (state_d == ON);
    fail_d = (state_d == FAULT);
  end

  // State register; outputs are registered alongside it so an async reset
  // drops every contactor at once.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= IDLE;
      tmr_q    <= '0;
      deb_q    <= '0;
      code_q   <= CODE_NONE;
      mc_q     <= 3'b000;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
`ifdef MC_FB_CHECK_EN
      fb_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      deb_q    <= deb_d;
      code_q   <= code_d;
      mc_q     <= mc_d;
      done_q   <= done_d;
      fail_q   <= fail_d;
`ifdef MC_FB_CHECK_EN
      fb_cnt_q <= fb_cnt_d;
`endif
    end
  end

  assign bus.o_mc        = mc_q;
  assign bus.o_state     = state_q;
  assign bus.o_done      = done_q;
  assign bus.o_fail      = fail_q;
  assign bus.o_fail_code = code_q;

endmodule

// File: tb/tb_mps_mc_seq.sv
// Scoreboard bench for mps_mc_seq: each scenario queues expected output
// snapshots tagged with a cycle index and compares them as the cycles elapse.
module tb_mps_mc_seq;
  localparam int DC_V_W     = 32;
  localparam int MC_DLY     = 10;
  localparam int V_DEB      = 4;
  localparam int PC_TIMEOUT = 50;
  localparam int DIS_TIME   = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mps_mc_seq_if #(.DC_V_W(DC_V_W)) bus ();

  mps_mc_seq #(
    .DC_V_W(DC_V_W), .MC_DLY(MC_DLY), .V_DEB(V_DEB),
    .PC_TIMEOUT(PC_TIMEOUT), .DIS_TIME(DIS_TIME)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  // Contactor model: aux contacts follow the drive unless forced.
  logic       fb_follow;
  logic [2:0] fb_force;
  assign bus.i_mc_fb = fb_follow ? bus.o_mc : fb_force;

  typedef struct {
    string       tag;
    int          at;
    logic [12:0] v;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic [12:0] obs;
  assign obs = {bus.o_state, bus.o_mc, bus.o_done, bus.o_fail, bus.o_fail_code};

  // Expected {state, mc, done, fail, code} from the state/drive table.
  function automatic logic [12:0] snap(input int st, input int code);
    logic [2:0] mc;
    case (st)
      1, 2:    mc = 3'b001;
      3:       mc = 3'b011;
      4, 5:    mc = 3'b010;
      7, 8:    mc = 3'b100;
      default: mc = 3'b000;
    endcase
    return {4'(st), mc, (st == 5), (st == 8), 4'(code)};
  endfunction

  task automatic expect_at(input string tag, input int at, input int st, input int code);
    exp_t e;
    e.tag = tag;
    e.at  = at;
    e.v   = snap(st, code);
    sb.push_back(e);
  endtask

  task automatic test_reset();
    bus.i_start = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (obs !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want %h", obs, 13'd0);
    end
    bus.i_start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (obs !== snap(0, 0)) begin
      miscompares++;
      $display("FAIL post_reset_idle: got %h want %h", obs, snap(0, 0));
    end
  endtask

  task automatic test_nominal();
    expect_at("nom_pc_close",   1,  1, 0);
    expect_at("nom_pc_hold",    10, 1, 0);
    expect_at("nom_wait_v",     11, 2, 0);
    expect_at("nom_wait_end",   14, 2, 0);
    expect_at("nom_main_close", 15, 3, 0);
    expect_at("nom_mc_hold",    24, 3, 0);
    expect_at("nom_pc_open",    25, 4, 0);
    expect_at("nom_not_done",   34, 4, 0);
    expect_at("nom_on_35",      35, 5, 0);
    expect_at("nom_on_hold",    36, 5, 0);
    expect_at("nom_main_open",  37, 6, 0);
    expect_at("nom_mo_hold",    46, 6, 0);
    expect_at("nom_discharge",  47, 7, 0);
    expect_at("nom_dis_hold",   66, 7, 0);
    expect_at("nom_idle",       67, 0, 0);
    bus.i_start = 1'b1;
    for (int c = 1; c <= 67; c++) begin
      @(negedge clk);
      while (sb.size() != 0 && sb[0].at == c) begin
        exp_t e = sb.pop_front();
        vectors++;
        if (obs !== e.v) begin
          miscompares++;
          $display("FAIL %s cyc %0d: got %h want %h", e.tag, c, obs, e.v);
        end
      end
      case (c)
        1:  bus.i_start = 1'b0;
        36: bus.i_stop  = 1'b1;
        37: bus.i_stop  = 1'b0;
        default: ;
      endcase
    end
  endtask

  task automatic test_timeout();
    expect_at("tmo_wait_v",  11, 2, 0);
    expect_at("tmo_last",    60, 2, 0);
    expect_at("tmo_fault",   61, 8, 2);
    expect_at("tmo_cleared", 62, 0, 0);
    bus.i_dc_v  = 32'd800;
    bus.i_start = 1'b1;
    for (int c = 1; c <= 62; c++) begin
      @(negedge clk);
      while (sb.size() != 0 && sb[0].at == c) begin
        exp_t e = sb.pop_front();
        vectors++;
        if (obs !== e.v) begin
          miscompares++;
          $display("FAIL %s cyc %0d: got %h want %h", e.tag, c, obs, e.v);
        end
      end
      case (c)
        1:  bus.i_start    = 1'b0;
        61: bus.i_fail_clr = 1'b1;
        62: bus.i_fail_clr = 1'b0;
        default: ;
      endcase
    end
    bus.i_dc_v = 32'd1000;
  endtask

  task automatic test_feedback();
    fb_follow = 1'b0;
    fb_force  = 3'b000;
`ifdef MC_FB_CHECK_EN
    expect_at("fb_pc_hold",  40, 1, 0);
    expect_at("fb_fault",    41, 8, 1);
    expect_at("fb_cleared",  42, 0, 0);
`else
    expect_at("fb_pc_close", 10, 1, 0);
    expect_at("fb_ignored",  11, 2, 0);
    expect_at("fb_stop",     12, 6, 0);
    expect_at("fb_idle",     42, 0, 0);
`endif
    bus.i_start = 1'b1;
    for (int c = 1; c <= 42; c++) begin
      @(negedge clk);
      while (sb.size() != 0 && sb[0].at == c) begin
        exp_t e = sb.pop_front();
        vectors++;
        if (obs !== e.v) begin
          miscompares++;
          $display("FAIL %s cyc %0d: got %h want %h", e.tag, c, obs, e.v);
        end
      end
      case (c)
        1:  bus.i_start    = 1'b0;
`ifdef MC_FB_CHECK_EN
        41: bus.i_fail_clr = 1'b1;
        42: bus.i_fail_clr = 1'b0;
`else
        11: bus.i_stop     = 1'b1;
        12: bus.i_stop     = 1'b0;
`endif
        default: ;
      endcase
    end
    fb_follow = 1'b1;
  endtask

  task automatic test_debounce();
    expect_at("deb_wait_v",     11, 2, 0);
    expect_at("deb_three_hi",   15, 2, 0);
    expect_at("deb_not_early",  19, 2, 0);
    expect_at("deb_main_close", 20, 3, 0);
    expect_at("deb_pc_open",    30, 4, 0);
    expect_at("deb_on",         40, 5, 0);
    bus.i_dc_v  = 32'd800;
    bus.i_start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      while (sb.size() != 0 && sb[0].at == c) begin
        exp_t e = sb.pop_front();
        vectors++;
        if (obs !== e.v) begin
          miscompares++;
          $display("FAIL %s cyc %0d: got %h want %h", e.tag, c, obs, e.v);
        end
      end
      case (c)
        1:  bus.i_start = 1'b0;
        12: bus.i_dc_v  = 32'd1000;
        15: bus.i_dc_v  = 32'd800;
        16: bus.i_dc_v  = 32'd1000;
        default: ;
      endcase
    end
  endtask

  task automatic test_interlock();
    expect_at("intl_fault",      1, 8, 5);
    expect_at("intl_clr_held",   2, 8, 5);
    expect_at("intl_start_ign",  3, 8, 5);
    expect_at("intl_cleared",    4, 0, 0);
    expect_at("intl_blk_start",  5, 0, 0);
    expect_at("intl_start_ok",   6, 1, 0);
    expect_at("intl_over_stop",  7, 8, 5);
    expect_at("intl_idle",       8, 0, 0);
    bus.i_intl = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      while (sb.size() != 0 && sb[0].at == c) begin
        exp_t e = sb.pop_front();
        vectors++;
        if (obs !== e.v) begin
          miscompares++;
          $display("FAIL %s cyc %0d: got %h want %h", e.tag, c, obs, e.v);
        end
      end
      case (c)
        1: bus.i_fail_clr = 1'b1;
        2: begin bus.i_fail_clr = 1'b0; bus.i_intl = 1'b0; bus.i_start = 1'b1; end
        3: begin bus.i_fail_clr = 1'b1; bus.i_start = 1'b0; end
        4: begin bus.i_fail_clr = 1'b0; bus.i_start = 1'b1; bus.i_intl = 1'b1; end
        5: bus.i_intl = 1'b0;
        6: begin bus.i_start = 1'b0; bus.i_stop = 1'b1; bus.i_intl = 1'b1; end
        7: begin bus.i_stop = 1'b0; bus.i_intl = 1'b0; bus.i_fail_clr = 1'b1; end
        8: bus.i_fail_clr = 1'b0;
        default: ;
      endcase
    end
  endtask

  task automatic test_stop();
    expect_at("stop_main_close", 17, 3, 0);
    expect_at("stop_main_open",  18, 6, 0);
    expect_at("stop_clr_noeff",  21, 6, 0);
    expect_at("stop_mo_hold",    27, 6, 0);
    expect_at("stop_discharge",  28, 7, 0);
    expect_at("stop_dis_hold",   47, 7, 0);
    expect_at("stop_idle",       48, 0, 0);
    bus.i_start = 1'b1;
    for (int c = 1; c <= 48; c++) begin
      @(negedge clk);
      while (sb.size() != 0 && sb[0].at == c) begin
        exp_t e = sb.pop_front();
        vectors++;
        if (obs !== e.v) begin
          miscompares++;
          $display("FAIL %s cyc %0d: got %h want %h", e.tag, c, obs, e.v);
        end
      end
      case (c)
        1:  bus.i_start    = 1'b0;
        17: bus.i_stop     = 1'b1;
        18: bus.i_stop     = 1'b0;
        20: bus.i_fail_clr = 1'b1;
        21: bus.i_fail_clr = 1'b0;
        default: ;
      endcase
    end
  endtask

  task automatic test_back_to_back();
    expect_at("b2b_on",        35, 5, 0);
    expect_at("b2b_main_open", 37, 6, 0);
    expect_at("b2b_dis_end",   66, 7, 0);
    expect_at("b2b_idle",      67, 0, 0);
    expect_at("b2b_restart",   68, 1, 0);
    expect_at("b2b_abort",     70, 6, 0);
    bus.i_start = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      while (sb.size() != 0 && sb[0].at == c) begin
        exp_t e = sb.pop_front();
        vectors++;
        if (obs !== e.v) begin
          miscompares++;
          $display("FAIL %s cyc %0d: got %h want %h", e.tag, c, obs, e.v);
        end
      end
      case (c)
        36: bus.i_stop = 1'b1;
        37: bus.i_stop = 1'b0;
        69: begin bus.i_stop = 1'b1; bus.i_start = 1'b0; end
        70: bus.i_stop = 1'b0;
        default: ;
      endcase
    end
  endtask

  task automatic test_reset_mid();
    expect_at("rmid_mo_hold",   9,  6, 0);
    expect_at("rmid_discharge", 10, 7, 0);
    expect_at("rmid_dis_hold",  12, 7, 0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      while (sb.size() != 0 && sb[0].at == c) begin
        exp_t e = sb.pop_front();
        vectors++;
        if (obs !== e.v) begin
          miscompares++;
          $display("FAIL %s cyc %0d: got %h want %h", e.tag, c, obs, e.v);
        end
      end
    end
    #1 rst = 1'b0;
    #1;
    vectors++;
    if (obs !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_async_drop: got %h want %h", obs, 13'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (obs !== snap(0, 0)) begin
      miscompares++;
      $display("FAIL reset_mid_idle: got %h want %h", obs, snap(0, 0));
    end
  endtask

  initial begin
    bus.i_start    = 1'b0;
    bus.i_stop     = 1'b0;
    bus.i_intl     = 1'b0;
    bus.i_fail_clr = 1'b0;
    bus.i_dc_v     = 32'd1000;
    bus.i_dc_v_th  = 32'd900;
    fb_follow      = 1'b1;
    fb_force       = 3'b000;

    test_reset();
    test_nominal();
    test_timeout();
    test_feedback();
    test_debounce();
    test_interlock();
    test_stop();
    test_back_to_back();
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule
